// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op classification for the multiply/divide unit.
// The accumulate ops are classified as multiply only when MULDIV_MADD_EN is defined.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MOVE
    } op_class_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    localparam int CNT_W = 4;

    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        cls = CLS_NONE;
        case (op)
            OP_MULT, OP_MULTU: cls = CLS_MUL;
            OP_DIV, OP_DIVU:   cls = CLS_DIV;
            OP_MTHI, OP_MTLO:  cls = CLS_MOVE;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
`endif
            default:           cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational product, quotient/remainder and (with MULDIV_MADD_EN) accumulate arithmetic.
// Result is presented as {hi, lo} for the op on i_op.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef MULDIV_MADD_EN
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
`endif
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo
);

    logic               w_sgn_mul;
    logic               w_sgn_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    // Extending both operands to 2*WIDTH makes the truncated product correct for signed and unsigned.
    assign w_sgn_mul = (i_op == OP_MULT) || (i_op == OP_MADD) || (i_op == OP_MSUB);
    assign w_a_ext   = w_sgn_mul ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign w_b_ext   = w_sgn_mul ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign w_prod    = w_a_ext * w_b_ext;

    // Sign-magnitude divide; most-negative / -1 falls out as most-negative with zero remainder.
    assign w_sgn_div = (i_op == OP_DIV);
    assign w_a_neg   = w_sgn_div & i_a[WIDTH-1];
    assign w_b_neg   = w_sgn_div & i_b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag   = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign w_q_mag   = w_a_mag / w_b_mag;
    assign w_r_mag   = w_a_mag % w_b_mag;
    assign w_q       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_r       = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

`ifdef MULDIV_MADD_EN
    logic [2*WIDTH-1:0] w_acc;
    assign w_acc = ((i_op == OP_MSUB) || (i_op == OP_MSUBU)) ? ({i_hi, i_lo} - w_prod)
                                                              : ({i_hi, i_lo} + w_prod);
`endif

    always_comb begin
        {o_res_hi, o_res_lo} = w_prod;
        case (i_op)
            OP_DIV, OP_DIVU: begin
                if (i_b == '0) begin
                    {o_res_hi, o_res_lo} = {i_a, {WIDTH{1'b1}}};
                end else begin
                    {o_res_hi, o_res_lo} = {w_r, w_q};
                end
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: {o_res_hi, o_res_lo} = w_acc;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: IDLE/RUN FSM, latency down-counter, HI/LO registers.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
//   state   | meaning
//   ST_IDLE | accepting start; MTHI/MTLO commit directly
//   ST_RUN  | result pending in r_pend_*, counting down to commit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    op_class_e        w_cls;

    assign w_cls = op_class(i_op);

    muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
`ifdef MULDIV_MADD_EN
        .i_hi    (r_hi),
        .i_lo    (r_lo),
`endif
        .o_res_hi(w_res_hi),
        .o_res_lo(w_res_lo)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_flush) begin
                        case (w_cls)
                            CLS_MUL, CLS_DIV: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_cnt     <= (w_cls == CLS_MUL) ? MULT_CNT : DIV_CNT;
                                r_busy    <= 1'b1;
                                r_state   <= ST_RUN;
                            end
                            CLS_MOVE: begin
                                if (i_op == OP_MTHI) begin
                                    r_hi <= i_a;
                                end else begin
                                    r_lo <= i_a;
                                end
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
// Define MULDIV_MADD_EN to check the accumulate ops as enabled.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_op   (op),
        .i_a    (a),
        .i_b    (b),
        .i_flush(flush),
        .o_busy (busy),
        .o_done (done),
        .o_hi   (hi),
        .o_lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi,lo} computed straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint sx, sy;
        logic [63:0] ps, pu;
        int q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ps = 64'(sx * sy);
        pu = {32'd0, x} * {32'd0, y};
        case (o)
            OP_MULT:  return ps;
            OP_MULTU: return pu;
            OP_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {32'(r), 32'(q)};
            end
            OP_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            OP_MADD:  return {h, l} + ps;
            OP_MADDU: return {h, l} + pu;
            OP_MSUB:  return {h, l} - ps;
            OP_MSUBU: return {h, l} - pu;
            default:  return {h, l};
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU: return ML;
            OP_DIV, OP_DIVU:   return DL;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return ML;
`endif
            default: return 0;
        endcase
    endfunction

    // Called at a negedge; issues one op, optionally re-requests start during the busy window.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit bump, input string tag);
        int lat;
        logic [63:0] e;
        lat = lat_of(o);
        e = (lat == 0) ? {m_hi, m_lo} : model(o, x, y, m_hi, m_lo);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (lat == 0) begin
            chk({tag, " noop busy/done"}, {62'd0, busy, done}, 64'd0);
            chk({tag, " noop hilo"}, {hi, lo}, e);
        end else begin
            for (int k = 0; k < lat; k++) begin
                chk({tag, " busy/done"}, {62'd0, busy, done}, 64'd2);
                if (bump && k == 0) begin
                    op = OP_DIVU; a = $urandom; b = $urandom; start = 1'b1;
                end
                @(negedge clk);
                start = 1'b0;
            end
            chk({tag, " commit busy/done"}, {62'd0, busy, done}, 64'd1);
            chk({tag, " hilo"}, {hi, lo}, e);
            {m_hi, m_lo} = e;
            @(negedge clk);
            chk({tag, " done drop"}, {63'd0, done}, 64'd0);
        end
    endtask

    task automatic move_op(input logic [3:0] o, input logic [31:0] x, input string tag);
        op = o; a = x; b = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (o == OP_MTHI) m_hi = x; else m_lo = x;
        chk({tag, " busy/done"}, {62'd0, busy, done}, 64'd1);
        chk({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        chk({tag, " done drop"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [3:0] rops [10];
        logic [3:0] ro;
        logic [31:0] ra, rb;
        rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};
        rst_n = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NONE; a = '0; b = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy/done", {62'd0, busy, done}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
        chk("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, "divu");
        chk("divu const", {hi, lo}, {32'd1, 32'd3});
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div neg");
        chk("div neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0, "div zero");
        chk("div zero const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
        chk("div ovf const", {hi, lo}, {32'd0, 32'h8000_0000});

        move_op(OP_MTHI, 32'h1234, "mthi");
        chk("mthi const", {32'd0, hi}, 64'h1234);
        move_op(OP_MTLO, 32'hCAFE_0001, "mtlo");
        run_op(OP_MULTU, 32'hDEAD_BEEF, 32'h1000_0001, 1'b1, "multu ignore");

        // Flush in RUN: hi/lo keep prior values, no done afterwards.
        op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flush pre busy", {63'd0, busy}, 64'd1);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy/done", {62'd0, busy, done}, 64'd0);
        chk("flush hilo", {hi, lo}, {m_hi, m_lo});
        for (int k = 0; k < ML; k++) begin
            @(negedge clk);
            chk("flush quiet", {62'd0, busy, done}, 64'd0);
        end

        // Flush concurrent with start suppresses both move and multi-cycle ops.
        op = OP_MTHI; a = 32'hDEAD_0000; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush+mthi busy/done", {62'd0, busy, done}, 64'd0);
        chk("flush+mthi hilo", {hi, lo}, {m_hi, m_lo});
        op = OP_MULT; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+mult busy/done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        chk("flush+mult hilo", {hi, lo}, {m_hi, m_lo});

        move_op(OP_MTHI, 32'd0, "madd setup hi");
        move_op(OP_MTLO, 32'hFFFF_FFFF, "madd setup lo");
        run_op(OP_MADDU, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MULDIV_MADD_EN
        chk("maddu const", {hi, lo}, {32'd1, 32'd0});
`else
        chk("maddu const", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

        for (int i = 0; i < 40; i++) begin
            ro = rops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (ro == OP_MTHI || ro == OP_MTLO) move_op(ro, ra, "rand move");
            else run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), "rand op");
        end

        // Reset in the middle of a divide clears everything at once.
        op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy/done", {62'd0, busy, done}, 64'd0);
        chk("midrun reset hilo", {hi, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DL; k++) begin
            @(negedge clk);
            chk("post-reset quiet", {62'd0, busy, done}, 64'd0);
        end
        run_op(OP_MULTU, 32'd9, 32'd11, 1'b0, "post-reset multu");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
